// File: rtl/image_engine_pkg.sv
// Shared definitions for the image engine controller.
// Holds the FSM state encoding, register offsets, CTRL/STATUS bit positions,
// the default kernel and the default frame size, plus a byte-strobe merge helper.
package image_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned FRAME_PIXELS_DEFAULT = 1024;

  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_STATUS = 5'h04;
  localparam logic [4:0] OFS_KERN0  = 5'h08;
  localparam logic [4:0] OFS_KERN1  = 5'h0C;
  localparam logic [4:0] OFS_KERN2  = 5'h10;
  localparam logic [4:0] OFS_DATA   = 5'h14;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_MODE_LO = 2;
  localparam int unsigned CTRL_IRQ_EN  = 4;

  localparam int unsigned STAT_STATE_LO  = 0;
  localparam int unsigned STAT_DONE      = 2;
  localparam int unsigned STAT_UNDERFLOW = 3;
  localparam int unsigned STAT_FIFO_LO   = 4;
  localparam int unsigned STAT_PIX_LO    = 16;

  // Write-one-to-clear positions differ from the read positions for underflow.
  localparam int unsigned W1C_DONE      = 2;
  localparam int unsigned W1C_UNDERFLOW = 7;

  localparam logic [71:0] KERNEL_DEFAULT = {9{8'h01}};

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = cur;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/image_engine_ctrl_fifo.sv
// ctrl_word_fifo: synchronous word FIFO holding packed result words.
// Ports: clk/rstn clock and async active-low reset; push/push_data write side;
// pop read side with head showing the oldest word; flush empties the FIFO;
// count/full/empty report occupancy. Flush has priority over push and pop.
module ctrl_word_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/image_engine_ctrl.sv
// image_engine_ctrl: register-mapped controller for a pixel processor.
// Ports: clk/rstn clock and async active-low reset; mem_* single-cycle bus
// (sel, 5-bit byte offset, wdata, wstrb with 0 meaning read, combinational rdata);
// proc_mode/proc_kernel configuration to the processor; proc_ready_in
// backpressure; proc_valid_out/proc_pixel_out processed pixel stream;
// irq_done level interrupt. Pixels are packed little-endian into 32-bit words
// and buffered in a FIFO that software drains through the DATA register.
module image_engine_ctrl
  import image_engine_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_sel,
  input  logic [4:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [1:0]  proc_mode,
  output logic [71:0] proc_kernel,
  output logic        proc_ready_in,
  input  logic        proc_valid_out,
  input  logic [7:0]  proc_pixel_out,
  output logic        irq_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  state_t        state_next;
  logic [1:0]    mode;
  logic          irq_en;
  logic [71:0]   kernel;
  logic          done;
  logic          underflow;
  logic [10:0]   pix_cnt;
  logic [1:0]    pack_idx;
  logic [23:0]   pack_lo;

  logic          wr_en, rd_en, ctrl_wr, status_wr;
  logic          start, abort, abort_run, frame_start, cfg_open;
  logic          accept, push, data_rd, pop;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  assign wr_en       = mem_sel && (mem_wstrb != '0);
  assign rd_en       = mem_sel && (mem_wstrb == '0);
  assign ctrl_wr     = wr_en && (mem_addr == OFS_CTRL) && mem_wstrb[0];
  assign status_wr   = wr_en && (mem_addr == OFS_STATUS) && mem_wstrb[0];
  assign start       = ctrl_wr && mem_wdata[CTRL_START];
  assign abort       = ctrl_wr && mem_wdata[CTRL_ABORT];
  assign abort_run   = abort && (state == ST_RUN);
  assign frame_start = start && !abort && (state == ST_IDLE);
  assign cfg_open    = (state == ST_IDLE);

  assign proc_ready_in = (state == ST_RUN) && !fifo_full;
  assign accept        = proc_valid_out && proc_ready_in;
  // The 4th byte goes straight into the pushed word rather than the packer.
  assign push          = accept && (pack_idx == 2'd3) && !abort_run;
  assign data_rd       = rd_en && (mem_addr == OFS_DATA);
  assign pop           = data_rd && !fifo_empty;

  assign proc_mode   = mode;
  assign proc_kernel = kernel;
  assign irq_done    = done && irq_en;

  ctrl_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data ({proc_pixel_out, pack_lo}),
    .pop       (pop),
    .flush     (abort_run),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (frame_start) state_next = ST_RUN;
      ST_RUN: begin
        if (abort)                              state_next = ST_IDLE;
        else if (pix_cnt == 11'(FRAME_PIXELS)) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_cnt  <= '0;
      pack_idx <= '0;
      pack_lo  <= '0;
    end else if (frame_start || abort_run) begin
      pix_cnt  <= '0;
      pack_idx <= '0;
      pack_lo  <= '0;
    end else if (accept) begin
      pix_cnt  <= pix_cnt + 11'd1;
      pack_idx <= pack_idx + 2'd1;
      case (pack_idx)
        2'd0:    pack_lo[7:0]   <= proc_pixel_out;
        2'd1:    pack_lo[15:8]  <= proc_pixel_out;
        2'd2:    pack_lo[23:16] <= proc_pixel_out;
        default: pack_lo        <= pack_lo;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode      <= '0;
      irq_en    <= 1'b0;
      kernel    <= KERNEL_DEFAULT;
      done      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en <= mem_wdata[CTRL_IRQ_EN];
        if (cfg_open) mode <= mem_wdata[CTRL_MODE_LO +: 2];
      end
      if (wr_en && cfg_open) begin
        case (mem_addr)
          OFS_KERN0: kernel[31:0]  <= merge_bytes(kernel[31:0], mem_wdata, mem_wstrb);
          OFS_KERN1: kernel[63:32] <= merge_bytes(kernel[63:32], mem_wdata, mem_wstrb);
          OFS_KERN2: if (mem_wstrb[0]) kernel[71:64] <= mem_wdata[7:0];
          default: ;
        endcase
      end
      if (state_next == ST_DONE)                    done <= 1'b1;
      else if (status_wr && mem_wdata[W1C_DONE])    done <= 1'b0;
      if (data_rd && fifo_empty)                    underflow <= 1'b1;
      else if (status_wr && mem_wdata[W1C_UNDERFLOW]) underflow <= 1'b0;
    end
  end

  always_comb begin
    mem_rdata = '0;
    case (mem_addr)
      OFS_CTRL: begin
        mem_rdata[CTRL_MODE_LO +: 2] = mode;
        mem_rdata[CTRL_IRQ_EN]       = irq_en;
      end
      OFS_STATUS: begin
        mem_rdata[STAT_STATE_LO +: 2] = state;
        mem_rdata[STAT_DONE]          = done;
        mem_rdata[STAT_UNDERFLOW]     = underflow;
        mem_rdata[STAT_FIFO_LO +: 4]  = 4'(fifo_count);
        mem_rdata[STAT_PIX_LO +: 11]  = pix_cnt;
      end
      OFS_KERN0: mem_rdata       = kernel[31:0];
      OFS_KERN1: mem_rdata       = kernel[63:32];
      OFS_KERN2: mem_rdata[7:0]  = kernel[71:64];
      OFS_DATA:  if (!fifo_empty) mem_rdata = fifo_head;
      default: ;
    endcase
  end

endmodule

// File: doc/image_engine_ctrl.md
IMAGE_ENGINE_CTRL -- requirements
Module: image_engine_ctrl

Interface
REQ-001 SHALL have parameter FRAME_PIXELS, default 1024, pixels per frame; legal values are multiples of 4 in the range 4..1024.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, number of 32-bit words in the result FIFO; legal values are powers of 2.
REQ-003 SHALL use one clock and an asynchronous active-low reset; all state SHALL be clocked on posedge clk and reset when rstn is low.
REQ-004 Port clk, input, 1: system clock.
REQ-005 Port rstn, input, 1: async active-low reset.
REQ-006 Port mem_sel, input, 1: one-cycle bus access strobe (ready returned the same cycle).
REQ-007 Port mem_addr, input, 5: local byte offset.
REQ-008 Port mem_wdata, input, 32: write data.
REQ-009 Port mem_wstrb, input, 4: byte enables; 0 = read.
REQ-010 Port mem_rdata, output, 32: combinational read data.
REQ-011 Port proc_mode, output, 2: processor mode.
REQ-012 Port proc_kernel, output, 72: nine 8-bit taps; tap n in [8n+7:8n].
REQ-013 Port proc_ready_in, output, 1: backpressure to the processor.
REQ-014 Port proc_valid_out, input, 1: processor output valid.
REQ-015 Port proc_pixel_out, input, 8: processed pixel.
REQ-016 Port irq_done, output, 1: level interrupt.

Function
REQ-017 Register map SHALL be: 0x00 CTRL (W); 0x04 STATUS (R, W1C); 0x08 KERN0 (taps 0-3); 0x0C KERN1 (taps 4-7); 0x10 KERN2 (tap 8 in [7:0]); 0x14 DATA (R, pop).
REQ-018 CTRL SHALL decode bit0 start (self-clearing), bit1 abort (self-clearing), [3:2] mode, bit4 irq_en; CTRL SHALL read back {27'b0, irq_en, mode, 2'b0}.
REQ-019 STATUS SHALL read {5'b0, pix_cnt[10:0], 8'b0, fifo_cnt[3:0], underflow, done, state[1:0]}; writing 1 to bit2 or bit7 SHALL clear done or underflow respectively.
REQ-020 FSM states SHALL be IDLE=0, RUN=1, DONE=2.
REQ-021 Transition IDLE->RUN SHALL occur on start; it SHALL clear pix_cnt and the packer and leave FIFO contents intact.
REQ-022 Transition RUN->DONE SHALL occur in the cycle after the accepted pixel that makes pix_cnt equal to FRAME_PIXELS.
REQ-023 Transition DONE->IDLE SHALL occur unconditionally after 1 cycle; entering DONE SHALL set sticky done.
REQ-024 Abort in RUN SHALL force IDLE next cycle, clear pix_cnt and the packer, and flush the FIFO; done SHALL NOT be set.
REQ-025 Start and abort asserted together SHALL resolve in favour of abort; start while in RUN or DONE SHALL be ignored.
REQ-026 Writes to mode and KERN0..KERN2 SHALL be ignored while state != IDLE; proc_mode and proc_kernel SHALL drive the register values directly.
REQ-027 proc_ready_in SHALL equal (state==RUN) && !fifo_full.
REQ-028 A pixel SHALL be accepted when proc_valid_out && proc_ready_in; each accepted pixel SHALL increment pix_cnt by 1.
REQ-029 Packer SHALL place the first pixel in [7:0] (little-endian); on the 4th pixel the word SHALL be pushed to the FIFO in that same cycle.
REQ-030 A DATA read (mem_sel, wstrb==0, offset 0x14) SHALL return the FIFO head combinationally and pop it at the clock edge.
REQ-031 A DATA read when the FIFO is empty SHALL return 0, leave the FIFO unchanged, and set underflow.
REQ-032 A push and a pop in the same cycle SHALL both succeed, leaving fifo_cnt unchanged; push is blocked by full only through REQ-027.
REQ-033 irq_done SHALL equal done && irq_en.
REQ-034 Reads at unmapped offsets SHALL return 0; writes to unmapped offsets SHALL be ignored.

Reset
REQ-035 Reset SHALL set state=IDLE, mode=0, irq_en=0, all kernel taps=8'h01, pix_cnt=0, packer empty, FIFO empty, done=0, underflow=0.
REQ-036 Outputs at reset SHALL be proc_ready_in=0, irq_done=0, proc_mode=0, proc_kernel=72'h010101010101010101.
REQ-037 Reset asserted mid-frame SHALL discard all partial and buffered data with no spurious push.

Structure
REQ-038 Shared package image_engine_pkg SHALL hold the state encoding, register offsets, CTRL/STATUS bit positions, the default kernel and the FRAME_PIXELS default.
REQ-039 The FIFO SHALL be a sub-module ctrl_word_fifo (synchronous, 32-bit wide, FIFO_DEPTH words, with count, full, empty and flush).

Verification
REQ-040 Reset, then read all registers -> CTRL=0, STATUS=0, KERN0..KERN2 read 0x01010101, 0x01010101, 0x00000001, proc_ready_in=0.
REQ-041 FRAME_PIXELS=8, start, drive pixels 0x10..0x17 -> DATA reads 0x13121110 then 0x17161514, STATUS.done=1, irq_done=1 when irq_en=1.
REQ-042 Run a frame without popping until the FIFO holds 8 words -> proc_ready_in=0 and pix_cnt holds; one DATA pop -> proc_ready_in returns to 1 next cycle.
REQ-043 Abort after 5 pixels -> state=IDLE, fifo_cnt=0, pix_cnt=0, done=0; a KERN0 write of 0xAABBCCDD then reads back.
REQ-044 KERN0 write during RUN -> value unchanged; DATA read with FIFO empty -> 0 and underflow=1; write 0x80 to STATUS -> underflow=0.
REQ-045 Start and abort in the same write -> state stays IDLE.
